// File: rtl/ff_pkg.sv
// Shared mode encodings for the ff_bank register bank.
// The bank and its bench both import these so they agree on every mode value.
package ff_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_LOAD   = 3'd1,
        MODE_SHL    = 3'd2,
        MODE_SHR    = 3'd3,
        MODE_ROTL   = 3'd4,
        MODE_ROTR   = 3'd5,
        MODE_TOGGLE = 3'd6,
        MODE_SETCLR = 3'd7
    } mode_e;

endpackage

// File: rtl/ff_cell.sv
// Single-bit register with a synchronous reset value, an enable, and a complementary output.
module ff_cell (
    input  logic c,
    input  logic r,
    input  logic en,
    input  logic nd,
    input  logic rv,
    output logic q,
    output logic qn
);

    logic q_d;
    logic q_q;

    always_comb begin
        q_d = q_q;
        if (en) begin
            q_d = nd;
        end
    end

    always_ff @(posedge c) begin
        if (r) begin
            q_q <= rv;
        end else begin
            q_q <= q_d;
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/ff_bank.sv
// WIDTH-bit register bank: hold, load, shift, rotate, toggle and masked set/clear,
// with a serial-out bit and a registered change flag.
module ff_bank
    import ff_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             c,
    input  logic             r,
    input  logic             en,
    input  logic [2:0]       m,
    input  logic [WIDTH-1:0] d,
    input  logic             si,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             so,
    output logic             chg
);

    logic [WIDTH-1:0] q_w;
    logic [WIDTH-1:0] qn_w;
    logic [WIDTH-1:0] nq;
    logic [WIDTH-1:0] si_vec;
    logic             so_d;
    logic             so_q;
    logic             chg_d;
    logic             chg_q;

    // Whole-vector shifts keep WIDTH=1 legal: shifts degenerate to q <= si, rotates to q <= q.
    always_comb begin
        si_vec    = '0;
        si_vec[0] = si;
        nq        = q_w;
        so_d      = so_q;
        case (m)
            MODE_HOLD:   nq = q_w;
            MODE_LOAD:   nq = d;
            MODE_SHL: begin
                nq   = (q_w << 1) | si_vec;
                so_d = q_w[WIDTH-1];
            end
            MODE_SHR: begin
                nq   = (q_w >> 1) | (si_vec << (WIDTH - 1));
                so_d = q_w[0];
            end
            MODE_ROTL: begin
                nq   = (q_w << 1) | (q_w >> (WIDTH - 1));
                so_d = q_w[WIDTH-1];
            end
            MODE_ROTR: begin
                nq   = (q_w >> 1) | (q_w << (WIDTH - 1));
                so_d = q_w[0];
            end
            MODE_TOGGLE: nq = q_w ^ d;
            MODE_SETCLR: nq = si ? (q_w | d) : (q_w & ~d);
            default:     nq = q_w;
        endcase
        if (!en) begin
            nq   = q_w;
            so_d = so_q;
        end
        chg_d = (nq != q_w);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .c  (c),
            .r  (r),
            .en (en),
            .nd (nq[i]),
            .rv (RESET_VAL[i]),
            .q  (q_w[i]),
            .qn (qn_w[i])
        );
    end

    always_ff @(posedge c) begin
        if (r) begin
            so_q  <= 1'b0;
            chg_q <= 1'b0;
        end else begin
            so_q  <= so_d;
            chg_q <= chg_d;
        end
    end

    assign q   = q_w;
    assign qn  = qn_w;
    assign so  = so_q;
    assign chg = chg_q;

endmodule

// File: tb/tb_ff_bank.sv
// Directed bench for ff_bank (WIDTH=8, RESET_VAL=0): one task per feature, inline checks.
module tb_ff_bank;
    import ff_pkg::*;

    logic       c;
    logic       r;
    logic       en;
    logic [2:0] m;
    logic [7:0] d;
    logic       si;
    logic [7:0] q;
    logic [7:0] qn;
    logic       so;
    logic       chg;

    int errors;
    int checks;

    ff_bank #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
        .c   (c),
        .r   (r),
        .en  (en),
        .m   (m),
        .d   (d),
        .si  (si),
        .q   (q),
        .qn  (qn),
        .so  (so),
        .chg (chg)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic drive(input logic [2:0] mode, input logic [7:0] data, input logic sin);
        r  = 1'b0;
        en = 1'b1;
        m  = mode;
        d  = data;
        si = sin;
        tick();
    endtask

    task automatic test_reset();
        r = 1'b1; en = 1'b1; m = MODE_LOAD; d = 8'hFF; si = 1'b1;
        tick();
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q: got %h expected %h", q, 8'h00); end
        checks++; if (qn !== 8'hFF) begin errors++; $display("FAIL reset_qn: got %h expected %h", qn, 8'hFF); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL reset_so: got %b expected 0", so); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL reset_chg: got %b expected 0", chg); end
    endtask

    task automatic test_load_hold();
        drive(MODE_LOAD, 8'hA5, 1'b0);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL load_q: got %h expected %h", q, 8'hA5); end
        checks++; if (qn !== 8'h5A) begin errors++; $display("FAIL load_qn: got %h expected %h", qn, 8'h5A); end
        checks++; if (chg !== 1'b1) begin errors++; $display("FAIL load_chg: got %b expected 1", chg); end
        drive(MODE_HOLD, 8'h3C, 1'b1);
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL hold_q: got %h expected %h", q, 8'hA5); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL hold_chg: got %b expected 0", chg); end
        // Make chg high again so the en=0 edge has to clear it.
        drive(MODE_TOGGLE, 8'h01, 1'b0);
        drive(MODE_TOGGLE, 8'h01, 1'b0);
        r = 1'b0; en = 1'b0; m = MODE_LOAD; d = 8'h00; si = 1'b0;
        tick();
        checks++; if (q !== 8'hA5) begin errors++; $display("FAIL disabled_q: got %h expected %h", q, 8'hA5); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL disabled_chg: got %b expected 0", chg); end
    endtask

    task automatic test_shift();
        drive(MODE_LOAD, 8'h81, 1'b0);
        drive(MODE_SHL, 8'h00, 1'b0);
        checks++; if (q !== 8'h02) begin errors++; $display("FAIL shl_q: got %h expected %h", q, 8'h02); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL shl_so: got %b expected 1", so); end
        drive(MODE_SHR, 8'h00, 1'b1);
        checks++; if (q !== 8'h81) begin errors++; $display("FAIL shr_q: got %h expected %h", q, 8'h81); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL shr_so: got %b expected 0", so); end
        drive(MODE_SHR, 8'h00, 1'b0);
        checks++; if (q !== 8'h40) begin errors++; $display("FAIL shr0_q: got %h expected %h", q, 8'h40); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL shr0_so: got %b expected 1", so); end
    endtask

    task automatic test_rotate();
        logic [7:0] exp_rot [8];
        exp_rot = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};
        drive(MODE_LOAD, 8'h81, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(MODE_ROTL, 8'h00, i[0]);
            checks++; if (q !== exp_rot[i]) begin errors++; $display("FAIL rotl_q[%0d]: got %h expected %h", i, q, exp_rot[i]); end
            checks++; if (chg !== 1'b1) begin errors++; $display("FAIL rotl_chg[%0d]: got %b expected 1", i, chg); end
        end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL rotl_so: got %b expected 1", so); end
        drive(MODE_ROTR, 8'h00, 1'b0);
        checks++; if (q !== 8'hC0) begin errors++; $display("FAIL rotr_q: got %h expected %h", q, 8'hC0); end
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL rotr_so: got %b expected 1", so); end
        // so holds through a non-shift mode.
        drive(MODE_LOAD, 8'h00, 1'b0);
        checks++; if (so !== 1'b1) begin errors++; $display("FAIL so_hold: got %b expected 1", so); end
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL load_zero_q: got %h expected %h", q, 8'h00); end
    endtask

    task automatic test_toggle_setclr();
        drive(MODE_LOAD, 8'h0F, 1'b0);
        drive(MODE_TOGGLE, 8'hFF, 1'b0);
        checks++; if (q !== 8'hF0) begin errors++; $display("FAIL toggle_q: got %h expected %h", q, 8'hF0); end
        drive(MODE_SETCLR, 8'h03, 1'b1);
        checks++; if (q !== 8'hF3) begin errors++; $display("FAIL set_q: got %h expected %h", q, 8'hF3); end
        drive(MODE_SETCLR, 8'hF0, 1'b0);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL clr_q: got %h expected %h", q, 8'h03); end
        checks++; if (chg !== 1'b1) begin errors++; $display("FAIL clr_chg: got %b expected 1", chg); end
        drive(MODE_TOGGLE, 8'h00, 1'b0);
        checks++; if (q !== 8'h03) begin errors++; $display("FAIL toggle0_q: got %h expected %h", q, 8'h03); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL toggle0_chg: got %b expected 0", chg); end
        drive(MODE_SETCLR, 8'h00, 1'b1);
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL setclr0_chg: got %b expected 0", chg); end
        drive(MODE_LOAD, 8'h03, 1'b0);
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL load_same_chg: got %b expected 0", chg); end
        checks++; if (qn !== 8'hFC) begin errors++; $display("FAIL load_same_qn: got %h expected %h", qn, 8'hFC); end
    endtask

    task automatic test_reset_mid();
        drive(MODE_LOAD, 8'h01, 1'b0);
        drive(MODE_ROTL, 8'h00, 1'b0);
        drive(MODE_ROTL, 8'h00, 1'b0);
        drive(MODE_ROTL, 8'h00, 1'b0);
        checks++; if (q !== 8'h08) begin errors++; $display("FAIL pre_reset_q: got %h expected %h", q, 8'h08); end
        r = 1'b1; en = 1'b1; m = MODE_ROTL; d = 8'h00; si = 1'b0;
        tick();
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_reset_q: got %h expected %h", q, 8'h00); end
        checks++; if (so !== 1'b0) begin errors++; $display("FAIL mid_reset_so: got %b expected 0", so); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL mid_reset_chg: got %b expected 0", chg); end
        drive(MODE_ROTL, 8'h00, 1'b1);
        checks++; if (q !== 8'h00) begin errors++; $display("FAIL post_reset_q: got %h expected %h", q, 8'h00); end
        checks++; if (chg !== 1'b0) begin errors++; $display("FAIL post_reset_chg: got %b expected 0", chg); end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        r = 1'b1; en = 1'b0; m = MODE_HOLD; d = 8'h00; si = 1'b0;
        test_reset();
        test_load_hold();
        test_shift();
        test_rotate();
        test_toggle_setclr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ff_bank.md
# ff_bank

Parametrised WIDTH-bit register bank with complementary outputs, successor to the single-bit D flip-flop. Every bit updates on the rising edge of one clock. A 3-bit mode input selects hold, parallel load, shift, rotate, toggle, or masked set/clear. A serial port and a change flag let banks be chained into shift chains or poll-free status registers. It sits wherever the lab designs need a multi-bit state element in place of discrete flip-flops.

## Interface
- WIDTH, 8, bits in the bank; legal range WIDTH >= 1
- RESET_VAL, {WIDTH{1'b0}}, value loaded into q on reset
- c  input  1  clock; all state changes on the rising edge
- r  input  1  synchronous reset, active-high; takes priority over every other input
- en  input  1  update enable; when 0, all state holds regardless of m
- m  input  3  mode select (encoding under Operation)
- d  input  WIDTH  parallel data, or bit mask in modes 6 and 7
- si  input  1  serial in for shifts; also the set/clear select in mode 7
- q  output  WIDTH  register contents
- qn  output  WIDTH  always ~q, derived combinationally from q with no separate state
- so  output  1  serial out: the bit that left (or wrapped) on the last shift or rotate
- chg  output  1  registered; 1 for the cycle after an edge at which q changed value

## Operation
Modes apply when r=0 and en=1; W = WIDTH.
- 0 HOLD: q unchanged.
- 1 LOAD: q <= d.
- 2 SHL: q <= {q[W-2:0], si}; so <= q[W-1].
- 3 SHR: q <= {si, q[W-1:1]}; so <= q[0].
- 4 ROTL: q <= {q[W-2:0], q[W-1]}; so <= q[W-1].
- 5 ROTR: q <= {q[0], q[W-1:1]}; so <= q[0].
- 6 TOGGLE: q <= q ^ d.
- 7 SETCLR: si=1 gives q <= q | d; si=0 gives q <= q & ~d.

Output rules:
- so updates only in modes 2-5. In all other modes, and when en=0, so holds.
- chg <= (next_q != q) on every non-reset edge. This includes en=0 edges, where chg <= 0.

## Timing
- Latency is one edge: inputs sampled at edge k appear on q, so and chg after edge k.
- Reset values: q=RESET_VAL, qn=~RESET_VAL, so=0, chg=0.
- Reset in the middle of a shift sequence discards the sequence. The next edge with r=0 operates from RESET_VAL.
- r=1 overrides en and m in the same edge.
- WIDTH=1 boundary:
  - SHL and SHR give q <= si and so <= old q.
  - ROTL and ROTR leave q unchanged, with so <= q and chg <= 0.
- Wrap-around: a rotation by W consecutive ROTL edges returns q to its original value.
- A LOAD of d equal to the current q gives chg <= 0.
- TOGGLE with d=0, and SETCLR with d=0, give chg <= 0.
- Modes 4 and 5 ignore si.
- No combinational path exists from any input to q, so or chg. The only combinational output logic is qn from q.

## Structure
- Shared package ff_pkg holds the mode constants: MODE_HOLD=0, MODE_LOAD=1, MODE_SHL=2, MODE_SHR=3, MODE_ROTL=4, MODE_ROTR=5, MODE_TOGGLE=6, MODE_SETCLR=7. ff_bank and its bench both import these.
- Sub-module ff_cell: a single-bit register with ports c, r, en, nd (next-state bit), rv (reset value bit), q, qn.
  - ff_bank generates WIDTH instances of ff_cell.
  - The per-bit next-state mux lives in ff_bank, because neighbour bits feed shifts and rotates.
- so and chg are separate registers in ff_bank that share c and r.

## Test plan
All scenarios use WIDTH=8 and RESET_VAL=8'h00.
- Reset: hold r=1 for 2 edges with en=1, m=LOAD, d=8'hFF -> q=8'h00, qn=8'hFF, so=0, chg=0.
- Load and hold:
  - LOAD d=8'hA5 -> q=8'hA5, qn=8'h5A, chg=1.
  - Then HOLD -> q stays 8'hA5, chg=0.
  - Then en=0 with m=LOAD, d=8'h00 -> q stays 8'hA5.
- Shift: from q=8'h81, SHL with si=0 -> q=8'h02, so=1. Then SHR with si=1 -> q=8'h81, so=0.
- Rotate: from q=8'h81, ROTL for 8 edges -> q=8'h81 again, chg=1 on each edge. ROTR once -> q=8'hC0, so=1.
- Toggle and set/clear: from q=8'h0F:
  - TOGGLE d=8'hFF -> q=8'hF0.
  - SETCLR si=1, d=8'h03 -> q=8'hF3.
  - SETCLR si=0, d=8'hF0 -> q=8'h03.
  - TOGGLE d=8'h00 -> q=8'h03, chg=0.
- Reset mid-operation: during a ROTL sequence from q=8'h01, assert r=1 for one edge after 3 rotations -> q=8'h00, so=0, chg=0. The next ROTL edge gives q=8'h00, chg=0.
